// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split width helpers for the direct-mapped I-cache.
package icache_pkg;

    localparam int unsigned DEF_NUM_LINES      = 32'd8;
    localparam int unsigned DEF_WORDS_PER_LINE = 32'd4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int unsigned off_w(input int unsigned words_per_line);
        return $clog2(words_per_line) + 32'd2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned num_lines, input int unsigned words_per_line);
        return 32'd32 - off_w(words_per_line) - idx_w(num_lines);
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and instruction-memory bus bundle; slave is the cache side, master the core/memory side.
interface icache_dm_if;
    logic [31:0] core_addr;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  core_addr, mem_rdata, mem_ack,
        output core_rdata, core_stall, mem_req, mem_addr
    );

    modport master (
        output core_addr, mem_rdata, mem_ack,
        input  core_rdata, core_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data storage: combinational read of one word, single word write, valid-set and invalidate-all.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int unsigned IW = idx_w(NUM_LINES),
    localparam int unsigned CW = $clog2(WORDS_PER_LINE),
    localparam int unsigned TW = tag_w(NUM_LINES, WORDS_PER_LINE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [CW-1:0] i_rd_off,
    output logic          o_rd_valid,
    output logic [TW-1:0] o_rd_tag,
    output logic [31:0]   o_rd_data,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [CW-1:0] i_wr_off,
    input  logic [31:0]   i_wr_data,
    input  logic          i_set_valid,
    input  logic [TW-1:0] i_set_tag,
    input  logic          i_inv_all
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES*WORDS_PER_LINE];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

    // Valid bits: invalidate-all wins over a same-cycle line completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= {NUM_LINES{1'b0}};
        end else if (i_inv_all) begin
            r_valid <= {NUM_LINES{1'b0}};
        end else if (i_set_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_set_valid) begin
            r_tag[i_wr_idx] <= i_set_tag;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill over a handshaked memory port.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    icache_dm_if.slave  bus
);

    localparam int unsigned OFF = off_w(WORDS_PER_LINE);
    localparam int unsigned IW  = idx_w(NUM_LINES);
    localparam int unsigned TW  = tag_w(NUM_LINES, WORDS_PER_LINE);
    localparam int unsigned CW  = $clog2(WORDS_PER_LINE);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_LINE - 1);

    state_e        r_state;
    state_e        w_next_state;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [CW-1:0] r_cnt;
    logic          r_drop;
    logic [IW-1:0] r_fill_idx;
    logic [TW-1:0] r_fill_tag;

    logic [IW-1:0] w_idx;
    logic [CW-1:0] w_off;
    logic [TW-1:0] w_tag;
    logic [31:0]   w_base;
    logic          w_rd_valid;
    logic [TW-1:0] w_rd_tag;
    logic [31:0]   w_rd_data;
    logic          w_hit;
    logic          w_ack;
    logic          w_last;
    logic          w_stall;
    logic [31:0]   w_rdata;
    logic          w_wr_en;
    logic          w_set_valid;
    logic          w_unused;

    assign w_idx    = bus.core_addr[OFF+IW-1:OFF];
    assign w_off    = bus.core_addr[OFF-1:2];
    assign w_tag    = bus.core_addr[31:OFF+IW];
    assign w_base   = {bus.core_addr[31:OFF], {OFF{1'b0}}};
    assign w_unused = &{1'b1, bus.core_addr[1:0]};
    assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
    assign w_ack    = bus.mem_ack && r_mem_req;
    assign w_last   = (r_cnt == LAST_WORD);

    icache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (w_idx),
        .i_rd_off    (w_off),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (r_fill_idx),
        .i_wr_off    (r_cnt),
        .i_wr_data   (bus.mem_rdata),
        .i_set_valid (w_set_valid),
        .i_set_tag   (r_fill_tag),
        .i_inv_all   (flush)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_hit) w_next_state = REFILL; else w_next_state = IDLE;
            REFILL:  if (w_ack && w_last) w_next_state = IDLE; else w_next_state = REFILL;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs and store controls; a flush on the final beat keeps the line invalid
    always_comb begin
        w_stall     = 1'b1;
        w_rdata     = 32'd0;
        w_wr_en     = 1'b0;
        w_set_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_stall = 1'b0;
                    w_rdata = w_rd_data;
                end else begin
                    w_stall = 1'b1;
                    w_rdata = 32'd0;
                end
            end
            REFILL: begin
                w_wr_en = w_ack;
                if (w_ack && w_last && !r_drop && !flush) w_set_valid = 1'b1;
                else                                     w_set_valid = 1'b0;
            end
            default: begin
                w_stall = 1'b1;
            end
        endcase
    end

    // Refill bookkeeping: registered request, word counter, drop flag and latched line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
            r_cnt      <= {CW{1'b0}};
            r_drop     <= 1'b0;
            r_fill_idx <= {IW{1'b0}};
            r_fill_tag <= {TW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_base;
                        r_cnt      <= {CW{1'b0}};
                        r_drop     <= flush;
                        r_fill_idx <= w_idx;
                        r_fill_tag <= w_tag;
                    end
                end
                REFILL: begin
                    if (flush) r_drop <= 1'b1;
                    if (w_ack) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) r_mem_req  <= 1'b0;
                        else        r_mem_addr <= r_mem_addr + 32'd4;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_stall = w_stall;
    assign bus.core_rdata = w_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Statistics: served hits not coinciding with flush, and IDLE-to-REFILL transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else begin
            if (r_state == IDLE && w_hit && !flush) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == IDLE && !w_hit)          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches against a line-level model.
module tb_icache_dm;

    localparam int unsigned NL         = 8;
    localparam int unsigned WPL        = 4;
    localparam int unsigned LINE_BYTES = WPL * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm_if bus();

    icache_dm #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
`ifdef ICACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_period   = 1;
    int ack_wait     = 0;
    logic [31:0] acked_q[$];
    int req_seen, unstable, bad_rdata;
    bit          ref_valid [NL];
    int unsigned ref_tag   [NL];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem_fn(bus.mem_addr);

    // Memory model: ack once every ack_period cycles of an outstanding request
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (ack_wait + 1 >= ack_period) begin
                bus.mem_ack = 1'b1;
                ack_wait = 0;
            end else begin
                bus.mem_ack = 1'b0;
                ack_wait = ack_wait + 1;
            end
        end else begin
            bus.mem_ack = (ack_period == 1);
            ack_wait = 0;
        end
    end

    // Present addr now (just after a negedge) and step cycles until served
    task automatic do_fetch(input logic [31:0] addr, input int flush_on_ack,
                            output int stalls, output logic [31:0] data);
        int n_acks;
        logic [31:0] prev_addr;
        bit have_prev, prev_acked;
        n_acks = 0; have_prev = 1'b0; prev_acked = 1'b0; prev_addr = 32'd0;
        acked_q.delete(); req_seen = 0; unstable = 0; bad_rdata = 0; stalls = 0;
        bus.core_addr = addr;
        flush = 1'b0;
        #1;
        while (bus.core_stall !== 1'b0 && stalls < 100) begin
            if (bus.core_rdata !== 32'd0) bad_rdata++;
            if (bus.mem_req === 1'b1) begin
                req_seen++;
                if (have_prev && !prev_acked && bus.mem_addr !== prev_addr) unstable++;
                have_prev  = 1'b1;
                prev_addr  = bus.mem_addr;
                prev_acked = (bus.mem_ack === 1'b1);
                if (bus.mem_ack === 1'b1) begin
                    acked_q.push_back(bus.mem_addr);
                    if (n_acks == flush_on_ack) flush = 1'b1;
                    n_acks++;
                end
            end
            stalls++;
            @(negedge clk);
            flush = 1'b0;
            #1;
        end
        if (bus.mem_req === 1'b1) req_seen++;
        data = bus.core_rdata;
        tests_run++;
        if (stalls >= 100) begin
            tests_failed++;
            $display("FAIL fetch_timeout addr=%h stalls=%0d required<100", addr, stalls);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic model_lookup(input logic [31:0] addr, input int period,
                                output int exp_stalls, output bit exp_miss);
        int unsigned idx, tag;
        idx = (addr / LINE_BYTES) % NL;
        tag = addr / (LINE_BYTES * NL);
        if (ref_valid[idx] && ref_tag[idx] == tag) begin
            exp_miss = 1'b0;
            exp_stalls = 0;
        end else begin
            exp_miss = 1'b1;
            exp_stalls = 1 + WPL * period;
            ref_valid[idx] = 1'b1;
            ref_tag[idx] = tag;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus.core_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall got=%b exp=1", bus.core_stall); end
        tests_run++;
        if (bus.core_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", bus.core_rdata); end
        tests_run++;
        if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        tests_run++;
        if (bus.mem_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
`ifdef ICACHE_STATS_EN
        tests_run++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", hit_cnt, miss_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        int stalls; logic [31:0] data;
        do_fetch(32'h0, -1, stalls, data);
        tests_run++;
        if (stalls != 5) begin tests_failed++; $display("FAIL cold_stalls got=%0d exp=5", stalls); end
        tests_run++;
        if (acked_q.size() != 4 || acked_q[0] !== 32'h0 || acked_q[1] !== 32'h4 ||
            acked_q[2] !== 32'h8 || acked_q[3] !== 32'hC) begin
            tests_failed++; $display("FAIL cold_mem_addr got_n=%0d exp=0,4,8,C", acked_q.size());
        end
        tests_run++;
        if (data !== 32'h1000_0000) begin tests_failed++; $display("FAIL cold_data got=%h exp=10000000", data); end
        tests_run++;
        if (bad_rdata != 0) begin tests_failed++; $display("FAIL cold_rdata_while_stalled got=%0d exp=0", bad_rdata); end
`ifdef ICACHE_STATS_EN
        tests_run++;
        if (miss_cnt !== 32'd1) begin tests_failed++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt); end
`endif
    endtask

    task automatic test_hit();
        int stalls; logic [31:0] data;
        for (int i = 0; i < 2; i++) begin
            do_fetch(32'h8 + 32'(i * 4), -1, stalls, data);
            tests_run++;
            if (stalls != 0 || req_seen != 0) begin
                tests_failed++; $display("FAIL hit_latency got=%0d/%0d exp=0/0", stalls, req_seen);
            end
            tests_run++;
            if (data !== 32'h1000_0008 + 32'(i * 4)) begin
                tests_failed++; $display("FAIL hit_data got=%h exp=%h", data, 32'h1000_0008 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_conflict();
        int stalls; logic [31:0] data;
        do_fetch(32'h80, -1, stalls, data);
        tests_run++;
        if (stalls != 5 || acked_q.size() != 4 || acked_q[0] !== 32'h80 || acked_q[3] !== 32'h8C) begin
            tests_failed++; $display("FAIL conflict_refill got=%0d/%0d exp=5/4", stalls, acked_q.size());
        end
        tests_run++;
        if (data !== 32'h1000_0080) begin tests_failed++; $display("FAIL conflict_data got=%h exp=10000080", data); end
        do_fetch(32'h0, -1, stalls, data);
        tests_run++;
        if (stalls != 5 || data !== 32'h1000_0000) begin
            tests_failed++; $display("FAIL conflict_evict got=%0d/%h exp=5/10000000", stalls, data);
        end
    endtask

    task automatic test_wait_states();
        int stalls; logic [31:0] data;
        ack_period = 3;
        do_fetch(32'h204, -1, stalls, data);
        ack_period = 1;
        tests_run++;
        if (stalls != 13) begin tests_failed++; $display("FAIL wait_penalty got=%0d exp=13", stalls); end
        tests_run++;
        if (unstable != 0 || acked_q.size() != 4 || acked_q[0] !== 32'h200) begin
            tests_failed++; $display("FAIL wait_addr_stable got=%0d/%0d exp=0/4", unstable, acked_q.size());
        end
        tests_run++;
        if (data !== 32'h1000_0204) begin tests_failed++; $display("FAIL wait_data got=%h exp=10000204", data); end
    endtask

    task automatic test_flush_mid_refill();
        int stalls; logic [31:0] data;
`ifdef ICACHE_STATS_EN
        logic [31:0] m0;
        m0 = miss_cnt;
`endif
        do_fetch(32'h40, 1, stalls, data);
        tests_run++;
        if (stalls != 10) begin tests_failed++; $display("FAIL flush_refetch_stalls got=%0d exp=10", stalls); end
        tests_run++;
        if (acked_q.size() != 8 || acked_q[4] !== 32'h40 || acked_q[7] !== 32'h4C) begin
            tests_failed++; $display("FAIL flush_refetch_seq got_n=%0d exp=8", acked_q.size());
        end
        tests_run++;
        if (data !== 32'h1000_0040) begin tests_failed++; $display("FAIL flush_data got=%h exp=10000040", data); end
`ifdef ICACHE_STATS_EN
        tests_run++;
        if (miss_cnt - m0 !== 32'd2) begin tests_failed++; $display("FAIL flush_miss_cnt got=%0d exp=2", miss_cnt - m0); end
`endif
    endtask

    task automatic test_random();
        int stalls, exp_stalls, bad_seq;
        bit exp_miss;
        logic [31:0] addr, data, base;
        do_flush();
        for (int it = 0; it < 40; it++) begin
            if (it > 0 && $urandom_range(0, 7) == 0) do_flush();
            ack_period = int'($urandom_range(1, 3));
            addr = 32'($urandom_range(0, 3)) * 32'h80 + 32'($urandom_range(0, 31)) * 32'd4;
            model_lookup(addr, ack_period, exp_stalls, exp_miss);
            do_fetch(addr, -1, stalls, data);
            base = addr - (addr % LINE_BYTES);
            bad_seq = 0;
            if (exp_miss) begin
                if (acked_q.size() != WPL) bad_seq++;
                else for (int i = 0; i < WPL; i++) if (acked_q[i] !== base + 32'(4 * i)) bad_seq++;
            end else if (acked_q.size() != 0) begin
                bad_seq++;
            end
            tests_run++;
            if (stalls != exp_stalls) begin
                tests_failed++; $display("FAIL rand_stalls addr=%h got=%0d exp=%0d", addr, stalls, exp_stalls);
            end
            tests_run++;
            if (data !== mem_fn(addr)) begin
                tests_failed++; $display("FAIL rand_data addr=%h got=%h exp=%h", addr, data, mem_fn(addr));
            end
            tests_run++;
            if (bad_seq != 0) begin
                tests_failed++; $display("FAIL rand_mem_seq addr=%h got_bad=%0d exp=0", addr, bad_seq);
            end
            tests_run++;
            if (bad_rdata + unstable != 0) begin
                tests_failed++; $display("FAIL rand_protocol addr=%h got=%0d exp=0", addr, bad_rdata + unstable);
            end
        end
        ack_period = 1;
    endtask

    task automatic test_reset_mid_refill();
        int n, stalls; logic [31:0] data;
        do_flush();
        bus.core_addr = 32'h20;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) n++;
        end
        tests_run++;
        if (n != 2) begin tests_failed++; $display("FAIL rstmid_reach got=%0d exp=2", n); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.core_stall !== 1'b1 || bus.core_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs got=%b/%b/%h exp=0/1/0", bus.mem_req, bus.core_stall, bus.core_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h0, -1, stalls, data);
        tests_run++;
        if (stalls != 5 || data !== 32'h1000_0000) begin
            tests_failed++; $display("FAIL rstmid_refetch got=%0d/%h exp=5/10000000", stalls, data);
        end
    endtask

    initial begin
        bus.core_addr = 32'h0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_wait_states();
        test_flush_mid_refill();
        test_random();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the single-cycle MIPS core's fetch port (IR_addr/IR) and a slow, handshaked instruction memory. Hits return the instruction combinationally in the same cycle. Misses raise core_stall and refill one full line from memory, one word per ack, before the fetch is served. The core gates its PC register with core_stall.

## Interface
- NUM_LINES, 8: number of lines; power of two, ≥2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- core_addr  in  32  fetch byte address; bits [1:0] ignored.
- core_rdata  out  32  instruction; valid when core_stall=0, otherwise 0.
- core_stall  out  1  1 = fetch not served this cycle; core holds PC.
- flush  in  1  synchronous invalidate-all pulse.
- mem_req  out  1  word read request; registered.
- mem_addr  out  32  word-aligned read address; registered, stable while mem_req=1.
- mem_rdata  in  32  read data; sampled on the cycle mem_ack=1.
- mem_ack  in  1  accepts mem_req and returns mem_rdata in the same cycle.

## Operation
- Address split, defaults: offset [3:2], index [6:4], tag [31:7]. In general: OFF=log2(WORDS_PER_LINE)+2 and IDX=log2(NUM_LINES).
- Storage: valid bit and tag per line; data array of NUM_LINES×WORDS_PER_LINE words.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = valid[idx] && tag[idx]==core_addr tag.
  - On hit: core_stall=0 and core_rdata=data[idx][off].
  - On miss: core_stall=1 combinationally. Latch the line base address, clear word counter and drop flag, set mem_req=1 and mem_addr=base, then go to REFILL.
- REFILL:
  - core_stall=1.
  - On each mem_ack: write mem_rdata to data[latched idx][cnt] and increment cnt.
  - If not the last word, mem_addr += 4 and mem_req stays 1.
  - On the last word: mem_req=0; set valid and tag unless drop=1; go to IDLE.
- Fill order: always word 0 upward. No critical-word-first.
- mem_ack while mem_req=0 is ignored.
- core_addr changes during REFILL are ignored. The refill completes for the latched line, then IDLE re-looks-up the current core_addr.
- flush in IDLE: clear all valid bits next edge. The current cycle's hit/miss result is still produced from the pre-flush state.
- flush in REFILL: clear all valid bits and set drop, so the line in flight is written but stays invalid.
- flush in the same cycle as a miss in IDLE: the refill starts with drop=1.
- Reset values, immediate on rst_n low:
  - state IDLE, mem_req 0, mem_addr 0, counter 0, all valid 0.
  - core_stall 1 and core_rdata 0, since every lookup misses.
  - Data and tag arrays are not reset.
- Reset mid-REFILL: mem_req drops immediately and the request is abandoned. The memory side tolerates a withdrawn request.

## Timing
- Hit: zero-cycle latency, combinational from core_addr.
- Miss, with mem_ack held high:
  - cycle 0: miss detected.
  - cycles 1..WORDS_PER_LINE: words arrive.
  - cycle WORDS_PER_LINE+1: IDLE hit, stall 0.
- Miss penalty is therefore WORDS_PER_LINE+1 cycles, plus memory wait cycles.
- mem_req and mem_addr are registered outputs; no combinational path from mem_ack to mem_req.

## Configuration
- ICACHE_STATS_EN defined: adds ports hit_cnt and miss_cnt, both out, 32 bits, reset 0, wrapping.
  - hit_cnt increments on every IDLE cycle with hit and no flush.
  - miss_cnt increments on every IDLE→REFILL transition.
- ICACHE_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package icache_pkg:
  - state enum (IDLE, REFILL);
  - OFF/IDX/TAG width functions derived from the parameters;
  - default parameter constants.
- Sub-module icache_line_store:
  - holds the valid/tag/data arrays;
  - provides a combinational read port and a single word write port;
  - provides valid-set and invalidate-all controls.
- The FSM, counter, drop flag and statistics stay in icache_dm.

## Test plan
- Cold miss:
  - Stimulus: after reset, core_addr=0x0; mem_ack=1 every cycle; memory returns 0x1000_0000+addr.
  - Response: mem_addr 0x0,0x4,0x8,0xC; stall high for 5 cycles; then core_rdata=0x1000_0000 with stall 0.
- Hit after fill: core_addr=0x8, then 0xC → zero-cycle hits returning 0x1000_0008 and 0x1000_000C; mem_req stays 0.
- Conflict eviction:
  - Stimulus: after line 0x0 is filled, core_addr=0x80 (same index 0, tag 1).
  - Response: refill of 0x80..0x8C. A later 0x0 misses again.
- Wait states: mem_ack asserted every third cycle → mem_addr holds stable until each ack; total miss penalty 13 cycles.
- Flush mid-refill:
  - Stimulus: flush pulse during the second word of the 0x40 refill.
  - Response: refill completes, then the 0x40 lookup misses again. With ICACHE_STATS_EN, miss_cnt increments by 2.
- Reset mid-refill: rst_n low during word 2 → mem_req=0 and core_stall=1 immediately; after release, 0x0 misses.
